// File: rtl/alu_seq_core.sv
// Sequential ALU: SUB/NAND finish in the accept cycle's edge, LEAD_ONES/ONEHOT scan {B,A} one bit per clock.
// One result register held until downstream handshake; accumulator feeds operand A on request.
module alu_seq_core #(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [1:0]       i_op,
    input  logic             i_acc,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_y,
    output logic             o_overflow,
    output logic             o_err,
    output logic             o_err_sticky,
    input  logic             i_clr_sticky
);
    localparam int SW = 2 * WIDTH;
    localparam int IW = $clog2(SW);
    localparam int CW = $clog2(SW + 1);
    localparam logic [1:0] OP_SUB    = 2'd0;
    localparam logic [1:0] OP_NAND   = 2'd1;
    localparam logic [1:0] OP_LEAD   = 2'd2;
    localparam logic [1:0] OP_ONEHOT = 2'd3;
    localparam logic [IW-1:0] IDX_TOP = IW'(SW - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t           state_q;
    logic [1:0]       op_q;
    logic [SW-1:0]    c_q;
    logic [IW-1:0]    idx_q;
    logic [CW-1:0]    cnt_q;
    logic [IW-1:0]    pos_q;
    logic             found_q, multi_q;
    logic [WIDTH-1:0] acc_q, y_q;
    logic             ovf_q, err_q, sticky_q, valid_q, ready_q;

    logic [WIDTH-1:0] op_a, sub_y, res_y;
    logic [1:0]       cur_op;
    logic [SW-1:0]    cur_c;
    logic [IW-1:0]    cur_idx, cur_pos, nxt_idx, oh_pos;
    logic [CW-1:0]    cur_cnt, lead_cnt;
    logic             cur_found, cur_multi, bit_v, oh_found, oh_multi;
    logic             res_ovf, res_err, res_last, step_en, done_entry;

    // The first bit is examined at the accept edge itself, straight from the inputs,
    // so a scan of n bits lands in DONE on the same cadence as a single-cycle op.
    always_comb begin
        op_a      = i_acc ? acc_q : i_a;
        sub_y     = op_a - i_b;
        cur_op    = op_q;
        cur_c     = c_q;
        cur_idx   = idx_q;
        cur_cnt   = cnt_q;
        cur_pos   = pos_q;
        cur_found = found_q;
        cur_multi = multi_q;
        if (state_q == IDLE) begin
            cur_op    = i_op;
            cur_c     = {i_b, op_a};
            cur_idx   = (i_op == OP_LEAD) ? IDX_TOP : '0;
            cur_cnt   = '0;
            cur_pos   = '0;
            cur_found = 1'b0;
            cur_multi = 1'b0;
        end
        bit_v    = cur_c[cur_idx];
        lead_cnt = cur_cnt + CW'(bit_v);
        oh_found = cur_found | bit_v;
        oh_multi = cur_multi | (cur_found & bit_v);
        oh_pos   = (bit_v && !cur_found) ? cur_idx : cur_pos;
        nxt_idx  = (cur_op == OP_LEAD) ? cur_idx - IW'(1) : cur_idx + IW'(1);

        res_y    = '0;
        res_ovf  = 1'b0;
        res_err  = 1'b0;
        res_last = 1'b1;
        case (cur_op)
            OP_SUB: begin
                res_y   = sub_y;
                res_ovf = (op_a[WIDTH-1] != i_b[WIDTH-1]) & (op_a[WIDTH-1] != sub_y[WIDTH-1]);
            end
            OP_NAND: res_y = ~(op_a & i_b);
            OP_LEAD: begin
                res_y    = WIDTH'(lead_cnt);
                res_ovf  = ((32'(lead_cnt) >> WIDTH) != 32'd0);
                res_last = !bit_v || (cur_idx == '0);
            end
            default: begin
                res_y    = oh_found ? WIDTH'(oh_pos) : '0;
                res_ovf  = oh_found && ((32'(oh_pos) >> WIDTH) != 32'd0);
                res_err  = oh_multi | !oh_found;
                res_last = (cur_idx == IDX_TOP);
            end
        endcase
        step_en    = (state_q == SCAN) || (state_q == IDLE && i_valid);
        done_entry = step_en && res_last;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= IDLE;
            op_q     <= '0;
            c_q      <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            pos_q    <= '0;
            found_q  <= 1'b0;
            multi_q  <= 1'b0;
            acc_q    <= '0;
            y_q      <= '0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
            sticky_q <= 1'b0;
            valid_q  <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            sticky_q <= (sticky_q & ~i_clr_sticky) | (done_entry & (res_err | res_ovf));
            if (done_entry) begin
                state_q <= DONE;
                y_q     <= res_y;
                ovf_q   <= res_ovf;
                err_q   <= res_err;
                acc_q   <= res_y;
                valid_q <= 1'b1;
                ready_q <= 1'b0;
            end else if (step_en) begin
                state_q <= SCAN;
                ready_q <= 1'b0;
                op_q    <= cur_op;
                c_q     <= cur_c;
                idx_q   <= nxt_idx;
                cnt_q   <= lead_cnt;
                pos_q   <= oh_pos;
                found_q <= oh_found;
                multi_q <= oh_multi;
            end else if (state_q == DONE && i_ready) begin
                state_q <= IDLE;
                valid_q <= 1'b0;
                ready_q <= 1'b1;
            end
        end
    end

    assign o_ready      = ready_q;
    assign o_valid      = valid_q;
    assign o_y          = y_q;
    assign o_overflow   = ovf_q;
    assign o_err        = err_q;
    assign o_err_sticky = sticky_q;
endmodule

// File: doc/alu_seq_core.md
# alu_seq_core

Sequential, parametrised successor to the combinational ALU library operators (subtract, NAND, leading ones, one-hot decode). It accepts one operation per valid/ready handshake, evaluates single-cycle operations in one clock, and evaluates the bit-scanning operations serially, one bit per clock. It holds the result in an output register until downstream accepts it. It keeps an accumulator so chained operations can reuse the previous result as operand A.

## Interface
- WIDTH, 4, operand and result width in bits (≥2); scan vector {B,A} is 2*WIDTH bits
- i_clk  in  1  clock, rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_valid  in  1  request valid
- o_ready  out  1  block can accept a request
- i_op  in  2  operation: 00 SUB, 01 NAND, 10 LEAD_ONES, 11 ONEHOT
- i_acc  in  1  1 = use accumulator instead of i_a as operand A
- i_a  in  WIDTH  operand A, signed two's complement
- i_b  in  WIDTH  operand B, signed two's complement
- o_valid  out  1  result valid
- i_ready  in  1  downstream accepts result
- o_y  out  WIDTH  result, signed
- o_overflow  out  1  overflow flag for the result
- o_err  out  1  error flag for the result
- o_err_sticky  out  1  OR of all completed o_err|o_overflow since reset/clear
- i_clr_sticky  in  1  synchronous clear of o_err_sticky

## Operation
- States: IDLE, SCAN, DONE.
  - IDLE: o_ready=1.
  - SCAN and DONE: o_ready=0.
- Accept: `i_valid & o_ready` at a rising edge latches i_op, operand A (i_a, or the accumulator if i_acc=1) and i_b.
- i_valid is ignored while o_ready=0.
- SUB and NAND: the result is computed from the latched operands and the block goes IDLE→DONE.
  - SUB: y = A−B, truncated to WIDTH. overflow = (A[MSB]≠B[MSB]) & (A[MSB]≠y[MSB]). err = 0.
  - NAND: y = ~(A&B). overflow = 0. err = 0.
- LEAD_ONES: go IDLE→SCAN.
  - Each SCAN cycle examines one bit of C={B,A}, starting at bit 2W−1 and moving down.
  - A 1 increments the count. A 0, or examining bit 0, ends the scan.
  - y = count[WIDTH−1:0]. overflow = count > 2^WIDTH−1. err = 0.
- ONEHOT: go IDLE→SCAN and always examine all 2W bits, from bit 0 upward.
  - posit = index of the lowest set bit.
  - err = 1 if more than one bit is set, or if no bit is set (new in this generation). If no bit is set, y = 0.
  - y = posit[WIDTH−1:0]. overflow = posit > 2^WIDTH−1.
- DONE: o_valid=1. o_y, o_overflow and o_err are held stable until `o_valid & i_ready`; the handshake returns the block to IDLE.
- Accumulator: loaded with y on entry to DONE. Reset value 0.
- o_err_sticky: set on entry to DONE if err|overflow. Cleared by i_clr_sticky when not being set in the same cycle; set wins.
- Reset (any time, including mid-SCAN or in DONE) clears everything asynchronously:
  - state = IDLE, o_ready = 1, o_valid = 0
  - o_y = 0, o_overflow = 0, o_err = 0
  - o_err_sticky = 0, accumulator = 0, scan counters = 0
- o_y, o_overflow and o_err are registered and change only on entry to DONE. They retain their last value while in IDLE and SCAN.

## Timing
- SUB and NAND: o_valid rises 1 cycle after the accept edge.
- Scan ops: o_valid rises n cycles after the accept edge, where n = number of bits examined.
  - LEAD_ONES: n = min(count+1, 2W).
  - ONEHOT: n = 2W.
- The earliest next accept is the cycle after the result handshake. o_ready rises the cycle after `o_valid & i_ready`. Maximum throughput is one op per 2 cycles.
- No combinational path from i_valid or i_ready to o_ready or o_valid.
- A chained i_acc request sees the accumulator value of the immediately preceding completed op.

## Test plan
- SUB, WIDTH=4, a=−8, b=1, i_ready=1 → o_valid 1 cycle after accept, o_y=7, o_overflow=1, o_err=0, o_err_sticky=1. Then i_clr_sticky → o_err_sticky=0.
- NAND a=4'hC, b=4'hA → o_y=4'h7, flags 0.
- LEAD_ONES:
  - a=4'hE, b=4'hF → o_y=7, o_valid 8 cycles after accept.
  - a=4'hF, b=4'h7 → o_y=0, latency 1.
  - a=4'hF, b=4'hF → o_y=4'b1000, o_overflow=0.
  - WIDTH=2, a=2'b11, b=2'b11 → count 4, o_y=0, o_overflow=1.
- ONEHOT:
  - a=0, b=4'h2 → o_y=5, o_err=0, latency 8.
  - a=1, b=1 → o_err=1, o_y=0.
  - a=0, b=0 → o_err=1, o_y=0.
- Backpressure and accumulate:
  - NAND result held with i_ready=0 for 3 cycles → o_y stable, o_ready=0, and a new i_valid is ignored.
  - After the handshake, SUB with i_acc=1, b=2 following a result of 5 → o_y=3.
- Reset mid-SCAN (ONEHOT, 3 cycles in) → o_valid=0 and o_ready=1 immediately. After release, a new SUB a=3, b=1 with i_acc=1 → o_y=−1 (accumulator 0).
